// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light conflict monitor.
// Holds the lamp code constants, the phase and monitor-state enums,
// the fault cause codes, and small helpers for decoding the code pair
// into a phase and for stepping through the legal phase order.
package tl_pkg;

  // Lamp codes, bit order {R,G,B}
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] OFF    = 3'b000;

  typedef enum logic [2:0] {PH_AG, PH_AY, PH_BG, PH_BY, PH_NONE} phase_t;

  typedef enum logic [1:0] {MON_SYNC, MON_RUN, MON_FAULT} mon_state_t;

  // Fault causes; a larger value means lower priority
  localparam logic [2:0] FLT_NONE     = 3'b000;
  localparam logic [2:0] FLT_CONFLICT = 3'b001;
  localparam logic [2:0] FLT_ILLEGAL  = 3'b010;
  localparam logic [2:0] FLT_SEQ      = 3'b011;
  localparam logic [2:0] FLT_SHORT    = 3'b100;
  localparam logic [2:0] FLT_TIMEOUT  = 3'b101;

  function automatic logic is_legal(input logic [2:0] code);
    return (code == RED) || (code == YELLOW) || (code == GREEN);
  endfunction

  function automatic phase_t decode_phase(input logic [2:0] a, input logic [2:0] b);
    if (a == GREEN && b == RED)  return PH_AG;
    if (a == YELLOW && b == RED) return PH_AY;
    if (a == RED && b == GREEN)  return PH_BG;
    if (a == RED && b == YELLOW) return PH_BY;
    return PH_NONE;
  endfunction

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_AG:   return PH_AY;
      PH_AY:   return PH_BG;
      PH_BG:   return PH_BY;
      PH_BY:   return PH_AG;
      default: return PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tl_conflict_monitor_if.sv
// Light-code bus between the traffic-light controller and the monitor.
// master: controller side (drives codes and clear_fault, sees lamp drive)
// slave : monitor side (sees codes, drives lamp outputs and fault status)
//   rgb1_in/rgb2_in : road A / road B codes {R,G,B}
//   clear_fault     : one-cycle pulse that leaves the fault state
//   rgb1_out/rgb2_out : lamp drive towards the board LEDs
//   fault, fault_code : fault flag and latched first cause
interface tl_conflict_monitor_if;
  logic [2:0] rgb1_in;
  logic [2:0] rgb2_in;
  logic       clear_fault;
  logic [2:0] rgb1_out;
  logic [2:0] rgb2_out;
  logic       fault;
  logic [2:0] fault_code;

  modport master (
    output rgb1_in, rgb2_in, clear_fault,
    input  rgb1_out, rgb2_out, fault, fault_code
  );

  modport slave (
    input  rgb1_in, rgb2_in, clear_fault,
    output rgb1_out, rgb2_out, fault, fault_code
  );
endinterface

// File: rtl/tl_flash_gen.sv
// Failsafe flash timing. Counts through an on half and an off half of
// FLASH_HALF cycles each while enabled, and clears when not enabled.
//   clk, reset : clock and synchronous active-high reset
//   enable     : high while the flash should run
//   lamp_on    : lamp state for the NEXT cycle, so the caller can load it
//                straight into a registered output and stay aligned
module tl_flash_gen #(
  parameter int FLASH_HALF = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic lamp_on
);
  localparam int PERIOD = 2 * FLASH_HALF;
  localparam int CW     = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] HALF = CW'(FLASH_HALF);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = '0;
    if (enable) begin
      cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  // Position of the upcoming cycle decides its lamp state
  assign lamp_on = (cnt_next < HALF);

  always_ff @(posedge clk) begin
    if (reset) cnt_reg <= '0;
    else       cnt_reg <= cnt_next;
  end
endmodule

// File: rtl/tl_conflict_monitor.sv
// Traffic-light conflict monitor. Watches the road A/B codes from the
// controller, passes them to the lamps with one cycle of latency, and on
// the first fault (conflicting greens, illegal code, bad phase order,
// short or overlong phase, or no A-green within SYNC_MAX cycles) latches
// the cause and flashes red on both roads until clear_fault.
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : slave side of tl_conflict_monitor_if (codes in, lamps/fault out)
module tl_conflict_monitor
  import tl_pkg::*;
#(
  parameter int GREEN_MIN  = 12,
  parameter int GREEN_MAX  = 12,
  parameter int YELLOW_MIN = 5,
  parameter int YELLOW_MAX = 5,
  parameter int SYNC_MAX   = 32,
  parameter int FLASH_HALF = 4,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  tl_conflict_monitor_if.slave  bus
);
  localparam logic [CNT_W-1:0] G_MIN    = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] G_MAX    = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] Y_MIN    = CNT_W'(YELLOW_MIN);
  localparam logic [CNT_W-1:0] Y_MAX    = CNT_W'(YELLOW_MAX);
  localparam logic [CNT_W-1:0] SYNC_LIM = CNT_W'(SYNC_MAX);

  mon_state_t       state_reg;
  phase_t           phase_reg;
  logic [CNT_W-1:0] dwell_reg;
  logic [CNT_W-1:0] sync_cnt_reg;
  logic             fault_reg;
  logic [2:0]       fault_code_reg;
  logic [2:0]       rgb1_out_reg;
  logic [2:0]       rgb2_out_reg;

  phase_t           cur_phase;
  phase_t           succ_phase;
  logic [CNT_W-1:0] dwell_min;
  logic [CNT_W-1:0] dwell_max;
  logic [2:0]       cause;
  logic             flash_en;
  logic             lamp_on;

  assign cur_phase  = decode_phase(bus.rgb1_in, bus.rgb2_in);
  assign succ_phase = next_phase(phase_reg);

  // Limits apply to the phase currently being held (the one we would leave)
  always_comb begin
    dwell_min = Y_MIN;
    dwell_max = Y_MAX;
    if (phase_reg == PH_AG || phase_reg == PH_BG) begin
      dwell_min = G_MIN;
      dwell_max = G_MAX;
    end
  end

  // Priority chain: CONFLICT > ILLEGAL > SEQ > SHORT > TIMEOUT
  always_comb begin
    cause = FLT_NONE;
    if (state_reg != MON_FAULT) begin
      if (bus.rgb1_in[1] && bus.rgb2_in[1]) begin
        cause = FLT_CONFLICT;
      end else if (!is_legal(bus.rgb1_in) || !is_legal(bus.rgb2_in)) begin
        cause = FLT_ILLEGAL;
      end else if (state_reg == MON_RUN) begin
        if (cur_phase == phase_reg) begin
          if (dwell_reg == dwell_max) cause = FLT_TIMEOUT;
        end else if (cur_phase == succ_phase) begin
          if (dwell_reg < dwell_min) cause = FLT_SHORT;
        end else begin
          cause = FLT_SEQ;
        end
      end else if (sync_cnt_reg == SYNC_LIM) begin
        cause = FLT_TIMEOUT;
      end
    end
  end

  // Held off on the clear cycle so the flash restarts from zero next time
  assign flash_en = (state_reg == MON_FAULT) && !bus.clear_fault;

  tl_flash_gen #(.FLASH_HALF(FLASH_HALF)) u_flash (
    .clk     (clk),
    .reset   (reset),
    .enable  (flash_en),
    .lamp_on (lamp_on)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= MON_SYNC;
      phase_reg      <= PH_AG;
      dwell_reg      <= '0;
      sync_cnt_reg   <= '0;
      fault_reg      <= 1'b0;
      fault_code_reg <= FLT_NONE;
      rgb1_out_reg   <= RED;
      rgb2_out_reg   <= RED;
    end else begin
      case (state_reg)
        MON_FAULT: begin
          if (bus.clear_fault) begin
            state_reg      <= MON_SYNC;
            fault_reg      <= 1'b0;
            fault_code_reg <= FLT_NONE;
            sync_cnt_reg   <= '0;
            rgb1_out_reg   <= bus.rgb1_in;
            rgb2_out_reg   <= bus.rgb2_in;
          end else begin
            rgb1_out_reg <= lamp_on ? RED : OFF;
            rgb2_out_reg <= lamp_on ? RED : OFF;
          end
        end
        default: begin
          if (cause != FLT_NONE) begin
            state_reg      <= MON_FAULT;
            fault_reg      <= 1'b1;
            fault_code_reg <= cause;
            rgb1_out_reg   <= RED;
            rgb2_out_reg   <= RED;
          end else begin
            rgb1_out_reg <= bus.rgb1_in;
            rgb2_out_reg <= bus.rgb2_in;
            if (state_reg == MON_SYNC) begin
              sync_cnt_reg <= sync_cnt_reg + 1'b1;
              if (cur_phase == PH_AG) begin
                state_reg <= MON_RUN;
                phase_reg <= PH_AG;
                dwell_reg <= CNT_W'(1);
              end
            end else if (cur_phase == phase_reg) begin
              if (dwell_reg != '1) dwell_reg <= dwell_reg + 1'b1;
            end else begin
              // Only a legal successor with enough dwell reaches here
              phase_reg <= cur_phase;
              dwell_reg <= CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign bus.rgb1_out   = rgb1_out_reg;
  assign bus.rgb2_out   = rgb2_out_reg;
  assign bus.fault      = fault_reg;
  assign bus.fault_code = fault_code_reg;
endmodule

// File: tb/tb_tl_conflict_monitor.sv
// Bench for tl_conflict_monitor: directed scenarios with literal
// expectations plus randomized controller traffic, all checked every
// cycle against a phase/run-length model of the monitor rules.
module tb_tl_conflict_monitor;
  localparam int GMIN = 12, GMAX = 12, YMIN = 5, YMAX = 5;
  localparam int SMAX = 32, FH = 4, CW = 6;
  localparam logic [2:0] R = 3'b100, Y = 3'b110, G = 3'b010, O = 3'b000;

  logic clk = 1'b0;
  logic reset = 1'b0;

  tl_conflict_monitor_if bus();

  tl_conflict_monitor #(
    .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_MIN(YMIN), .YELLOW_MAX(YMAX),
    .SYNC_MAX(SMAX), .FLASH_HALF(FH), .CNT_W(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // state: 0 sync, 1 run, 2 fault; phase index 0..3 = AG,AY,BG,BY, 4 = none
  int m_st = 0, m_ph = 0, m_len = 0, m_sync = 0, m_age = 0;
  logic       m_fault = 1'b0;
  logic [2:0] m_code = 3'b000;
  logic [2:0] m_out1 = R, m_out2 = R;
  int ph_min[4] = '{GMIN, YMIN, GMIN, YMIN};
  int ph_max[4] = '{GMAX, YMAX, GMAX, YMAX};

  function automatic bit ok(input logic [2:0] c);
    return (c == R) || (c == Y) || (c == G);
  endfunction

  function automatic int ph_of(input logic [2:0] a, input logic [2:0] b);
    if (a == G && b == R) return 0;
    if (a == Y && b == R) return 1;
    if (a == R && b == G) return 2;
    if (a == R && b == Y) return 3;
    return 4;
  endfunction

  task automatic model_step();
    logic [2:0] a, b;
    int cur, cause;
    a = bus.rgb1_in;
    b = bus.rgb2_in;
    if (reset) begin
      m_st = 0; m_ph = 0; m_len = 0; m_sync = 0; m_age = 0;
      m_fault = 1'b0; m_code = 3'b000; m_out1 = R; m_out2 = R;
      return;
    end
    if (m_st == 2) begin
      if (bus.clear_fault) begin
        m_st = 0; m_fault = 1'b0; m_code = 3'b000; m_sync = 0;
        m_out1 = a; m_out2 = b;
      end else begin
        m_age++;
        m_out1 = ((m_age % (2 * FH)) < FH) ? R : O;
        m_out2 = m_out1;
      end
      return;
    end
    cur = ph_of(a, b);
    cause = 0;
    if (a[1] && b[1]) cause = 1;
    else if (!ok(a) || !ok(b)) cause = 2;
    else if (m_st == 1) begin
      if (cur == m_ph) begin
        if (m_len == ph_max[m_ph]) cause = 5;
      end else if (cur == (m_ph + 1) % 4) begin
        if (m_len < ph_min[m_ph]) cause = 4;
      end else cause = 3;
    end else if (m_sync == SMAX) cause = 5;

    if (cause != 0) begin
      m_st = 2; m_fault = 1'b1; m_code = 3'(cause); m_age = 0;
      m_out1 = R; m_out2 = R;
    end else begin
      m_out1 = a; m_out2 = b;
      if (m_st == 0) begin
        m_sync++;
        if (cur == 0) begin m_st = 1; m_ph = 0; m_len = 1; end
      end else if (cur == m_ph) begin
        if (m_len < (1 << CW) - 1) m_len++;
      end else begin
        m_ph = cur; m_len = 1;
      end
    end
  endtask

  // Single compare process, sampling away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("rgb1_out", bus.rgb1_out, m_out1);
      check("rgb2_out", bus.rgb2_out, m_out2);
      check("fault", bus.fault, m_fault);
      check("fault_code", bus.fault_code, m_code);
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a falling edge; returns just after the next one.
  task automatic step(input logic [2:0] a, input logic [2:0] b, input logic clr, input logic rst);
    bus.rgb1_in = a;
    bus.rgb2_in = b;
    bus.clear_fault = clr;
    reset = rst;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic run(input logic [2:0] a, input logic [2:0] b, input int n);
    for (int i = 0; i < n; i++) step(a, b, 1'b0, 1'b0);
  endtask

  task automatic legal_cycle();
    run(G, R, GMIN);
    run(Y, R, YMIN);
    run(R, G, GMIN);
    run(R, Y, YMIN);
  endtask

  initial begin
    int seg_ph, seg_len, seg_pos, base, v, r;
    logic [2:0] a, b;
    logic clr, rst;

    bus.rgb1_in = R;
    bus.rgb2_in = R;
    bus.clear_fault = 1'b0;
    @(negedge clk);

    // Reset state
    step(R, R, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(R, R, 1'b0, 1'b1);
    check("rst_out1", bus.rgb1_out, 3'b100);
    check("rst_out2", bus.rgb2_out, 3'b100);
    check("rst_fault", bus.fault, 1'b0);
    check("rst_code", bus.fault_code, 3'b000);

    // Three full legal cycles
    step(R, R, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) legal_cycle();
    check("legal_fault", bus.fault, 1'b0);
    check("legal_pass", bus.rgb2_out, 3'b110);

    // Conflict during AG, then the flash pattern
    step(R, R, 1'b0, 1'b1);
    run(G, R, 5);
    step(G, G, 1'b0, 1'b0);
    check("conf_code", bus.fault_code, 3'b001);
    check("conf_fault", bus.fault, 1'b1);
    check("conf_on0", bus.rgb1_out, 3'b100);
    run(G, R, 3);
    check("conf_on3", bus.rgb2_out, 3'b100);
    step(G, R, 1'b0, 1'b0);
    check("conf_off4", bus.rgb1_out, 3'b000);
    run(G, R, 4);
    check("conf_on8", bus.rgb1_out, 3'b100);

    // Short green
    step(R, R, 1'b0, 1'b1);
    run(G, R, 8);
    step(Y, R, 1'b0, 1'b0);
    check("short_code", bus.fault_code, 3'b100);

    // Yellow held one cycle too long
    step(R, R, 1'b0, 1'b1);
    run(G, R, 12);
    run(Y, R, 5);
    check("tmo_nofault", bus.fault, 1'b0);
    step(Y, R, 1'b0, 1'b0);
    check("tmo_code", bus.fault_code, 3'b101);

    // Out-of-order phase
    step(R, R, 1'b0, 1'b1);
    run(G, R, 12);
    step(R, G, 1'b0, 1'b0);
    check("seq_code", bus.fault_code, 3'b011);

    // Conflict outranks illegal
    step(R, R, 1'b0, 1'b1);
    step(3'b111, G, 1'b0, 1'b0);
    check("prio_code", bus.fault_code, 3'b001);

    // Recovery, then SYNC timeout holding BG
    step(R, G, 1'b1, 1'b0);
    check("clr_code", bus.fault_code, 3'b000);
    check("clr_fault", bus.fault, 1'b0);
    check("clr_pass", bus.rgb2_out, 3'b010);
    run(R, G, 32);
    check("sync_nofault", bus.fault, 1'b0);
    step(R, G, 1'b0, 1'b0);
    check("sync_tmo", bus.fault_code, 3'b101);

    // Reset during flash-off
    run(R, G, 5);
    check("off_pin", bus.rgb1_out, 3'b000);
    step(R, R, 1'b0, 1'b1);
    check("rstf_out", bus.rgb1_out, 3'b100);
    check("rstf_code", bus.fault_code, 3'b000);

    // Reset at RUN dwell 7, then a clean green/yellow
    run(G, R, 7);
    step(R, R, 1'b0, 1'b1);
    check("rstr_out", bus.rgb2_out, 3'b100);
    check("rstr_fault", bus.fault, 1'b0);
    run(G, R, 12);
    step(Y, R, 1'b0, 1'b0);
    check("after_rst_ok", bus.fault, 1'b0);

    // Randomized controller traffic with occasional glitches
    seg_ph = 0; seg_len = GMIN; seg_pos = 0;
    for (int c = 0; c < 2500; c++) begin
      if (seg_pos >= seg_len) begin
        seg_ph = (seg_ph + 1) % 4;
        base = (seg_ph % 2 == 0) ? GMIN : YMIN;
        v = $urandom_range(0, 9);
        seg_len = (v == 0) ? base - 1 : (v == 1) ? base + 1 : base;
        seg_pos = 0;
      end
      r = $urandom_range(0, 99);
      if (r == 3) seg_ph = $urandom_range(0, 3);
      case (seg_ph)
        0: begin a = G; b = R; end
        1: begin a = Y; b = R; end
        2: begin a = R; b = G; end
        default: begin a = R; b = Y; end
      endcase
      if (r < 3) begin
        a = 3'($urandom_range(0, 7));
        b = 3'($urandom_range(0, 7));
      end
      clr = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step(a, b, clr, rst);
      seg_pos++;
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
